ym_clk_phase_gen: RTL and testbench

//  Two-phase clock generator feeding the common cells' c1/c2 latch enables from MCLK.

---
 rtl/ym_clk_pkg.sv | 20 ++
 rtl/ym_clk_phase_gen_if.sv | 38 +++
 rtl/ym_clk_phase_decode.sv | 17 +
 rtl/ym_clk_phase_gen.sv | 116 +++++++++++
 tb/tb_ym_clk_phase_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ym_clk_pkg.sv
// Shared constants and the c1/c2 phase decode for the YM two-phase clock generator.
// Pure combinational helpers, no state; no flow control.
package ym_clk_pkg;

    localparam int YM_DIV_DEFAULT = 6;
    localparam int YM_SLOTS_OPN   = 24;
    localparam int YM_GAP_DEFAULT = 1;

    // Returns {c2, c1}; each phase is followed by GAP dead cycles so the two never overlap.
    function automatic logic [1:0] ym_clk_phase(input int unsigned ph,
                                                input int unsigned div,
                                                input int unsigned gap);
        logic c1;
        logic c2;
        c1 = (ph < (div / 2) - gap);
        c2 = (ph >= (div / 2)) && (ph < div - gap);
        return {c2, c1};
    endfunction

endpackage

// File: rtl/ym_clk_phase_gen_if.sv
// Control inputs and clock-phase outputs of the YM two-phase clock generator.
// Wiring only, no latency; clk_en is the only stall control.
interface ym_clk_phase_gen_if
    import ym_clk_pkg::*;
#(
    parameter int SLOTS = YM_SLOTS_OPN
);
    localparam int SW = $clog2(SLOTS);

    logic          clk_en;
    logic          sync_in;
    logic          c1;
    logic          c2;
    logic [SW-1:0] slot;
    logic          sync_out;
    logic [15:0]   dbg_periods;

    modport master (
        input  clk_en,
        input  sync_in,
        output c1,
        output c2,
        output slot,
        output sync_out,
        output dbg_periods
    );

    modport slave (
        output clk_en,
        output sync_in,
        input  c1,
        input  c2,
        input  slot,
        input  sync_out,
        input  dbg_periods
    );

endinterface

// File: rtl/ym_clk_phase_decode.sv
// Combinational ph -> {c1,c2} decode, reusable by any domain running the same divider.
// Zero latency; no flow control.
module ym_clk_phase_decode
    import ym_clk_pkg::*;
#(
    parameter int DIV = YM_DIV_DEFAULT,
    parameter int GAP = YM_GAP_DEFAULT,
    parameter int PW  = $clog2(DIV)
) (
    input  logic [PW-1:0] ph,
    output logic          c1,
    output logic          c2
);

    assign {c2, c1} = ym_clk_phase(32'(ph), DIV, GAP);

endmodule

// File: rtl/ym_clk_phase_gen.sv
// Two-phase c1/c2 generator with slot counter and per-frame sync; optional period counter under YM_CLK_PHASE_DBG_EN.
// Outputs registered, 1 MCLK behind the internal phase counter.
// clk_en=0 freezes all state and outputs; sync_in realigns to the post-reset state regardless of clk_en.
module ym_clk_phase_gen
    import ym_clk_pkg::*;
#(
    parameter int DIV   = YM_DIV_DEFAULT,
    parameter int GAP   = YM_GAP_DEFAULT,
    parameter int SLOTS = YM_SLOTS_OPN
) (
    input  logic                 MCLK,
    input  logic                 reset,
    ym_clk_phase_gen_if.master   bus
);

    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(SLOTS);

    if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
        $error("ym_clk_phase_gen: DIV must be even and >= 4");
    end
    if (GAP < 1 || GAP > (DIV / 2) - 1) begin : g_bad_gap
        $error("ym_clk_phase_gen: GAP must be in 1..DIV/2-1");
    end
    if (SLOTS < 2) begin : g_bad_slots
        $error("ym_clk_phase_gen: SLOTS must be >= 2");
    end

    logic [PW-1:0] ph_q;
    logic [SW-1:0] slot_cnt_q;
    logic          c1_q;
    logic          c2_q;
    logic [SW-1:0] slot_q;
    logic          sync_q;

    logic          dec_c1;
    logic          dec_c2;
    logic          ph_last;
    logic          slot_last;
    logic [PW-1:0] ph_nxt;
    logic [SW-1:0] slot_cnt_nxt;

    ym_clk_phase_decode #(
        .DIV (DIV),
        .GAP (GAP),
        .PW  (PW)
    ) u_decode (
        .ph  (ph_q),
        .c1  (dec_c1),
        .c2  (dec_c2)
    );

    assign ph_last   = (ph_q == PW'(DIV - 1));
    assign slot_last = (slot_cnt_q == SW'(SLOTS - 1));

    always_comb begin
        ph_nxt       = ph_q + PW'(1);
        slot_cnt_nxt = slot_cnt_q;
        if (ph_last) begin
            ph_nxt       = '0;
            slot_cnt_nxt = slot_last ? '0 : slot_cnt_q + SW'(1);
        end
    end

    // Outputs load from the pre-edge counters, so they trail ph/slot_cnt by one MCLK.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            ph_q       <= '0;
            slot_cnt_q <= '0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            slot_q     <= '0;
            sync_q     <= 1'b0;
        end else if (bus.sync_in) begin
            ph_q       <= '0;
            slot_cnt_q <= '0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            slot_q     <= '0;
            sync_q     <= 1'b0;
        end else if (bus.clk_en) begin
            ph_q       <= ph_nxt;
            slot_cnt_q <= slot_cnt_nxt;
            c1_q       <= dec_c1;
            c2_q       <= dec_c2;
            slot_q     <= slot_cnt_q;
            sync_q     <= slot_last;
        end
    end

    assign bus.c1       = c1_q;
    assign bus.c2       = c2_q;
    assign bus.slot     = slot_q;
    assign bus.sync_out = sync_q;

`ifdef YM_CLK_PHASE_DBG_EN
    logic [15:0] dbg_q;

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            dbg_q <= '0;
        end else if (bus.sync_in) begin
            dbg_q <= '0;
        end else if (bus.clk_en && ph_last) begin
            dbg_q <= dbg_q + 16'd1;
        end
    end

    assign bus.dbg_periods = dbg_q;
`else
    assign bus.dbg_periods = '0;
`endif

    a_no_overlap : assert property (@(posedge MCLK) disable iff (!reset) !(c1_q && c2_q));

endmodule

// File: tb/tb_ym_clk_phase_gen.sv
// Bench for ym_clk_phase_gen: edge-count model checked every cycle plus directed literal checks.
module tb_ym_clk_phase_gen;

    localparam int DIV   = 6;
    localparam int GAP   = 1;
    localparam int SLOTS = 24;

    logic MCLK;
    logic rst;
    int   checks;
    int   errors;
    longint n_edges;

    ym_clk_phase_gen_if #(.SLOTS(SLOTS)) bus ();

    ym_clk_phase_gen #(
        .DIV   (DIV),
        .GAP   (GAP),
        .SLOTS (SLOTS)
    ) dut (
        .MCLK  (MCLK),
        .reset (rst),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: enabled edges since the last reset or sync.
    always @(posedge MCLK or negedge rst) begin
        if (!rst)              n_edges <= 0;
        else if (bus.sync_in)  n_edges <= 0;
        else if (bus.clk_en)   n_edges <= n_edges + 1;
    end

    always @(negedge MCLK) begin
        longint q;
        longint p;
        logic   e_c1, e_c2, e_sync;
        logic [31:0] e_slot, e_dbg;
        e_c1 = 0; e_c2 = 0; e_sync = 0; e_slot = 0; e_dbg = 0;
        if (n_edges > 0) begin
            q      = (n_edges - 1) % DIV;
            p      = (n_edges - 1) / DIV;
            e_c1   = (q < DIV / 2 - GAP);
            e_c2   = (q >= DIV / 2) && (q < DIV - GAP);
            e_slot = 32'(p % SLOTS);
            e_sync = (e_slot == SLOTS - 1);
        end
`ifdef YM_CLK_PHASE_DBG_EN
        e_dbg = 32'((n_edges / DIV) % 65536);
`endif
        chk("model_c1",   32'(bus.c1),          32'(e_c1));
        chk("model_c2",   32'(bus.c2),          32'(e_c2));
        chk("model_slot", 32'(bus.slot),        e_slot);
        chk("model_sync", 32'(bus.sync_out),    32'(e_sync));
        chk("model_dbg",  32'(bus.dbg_periods), e_dbg);
        chk("no_overlap", 32'(bus.c1 & bus.c2), 0);
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    bit c1_pat [6] = '{1, 1, 0, 0, 0, 0};
    bit c2_pat [6] = '{0, 0, 0, 1, 1, 0};

    initial begin
        int sync_cnt;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.clk_en  = 1'b1;
        bus.sync_in = 1'b0;

        tick(3);
        chk("rst_c1",   32'(bus.c1),       0);
        chk("rst_c2",   32'(bus.c2),       0);
        chk("rst_slot", 32'(bus.slot),     0);
        chk("rst_sync", 32'(bus.sync_out), 0);
        chk("rst_dbg",  32'(bus.dbg_periods), 0);
        rst = 1'b1;

        // first period pattern
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("pat_c1", 32'(bus.c1), 32'(c1_pat[i]));
            chk("pat_c2", 32'(bus.c2), 32'(c2_pat[i]));
        end

        // rest of the first frame and into the next
        sync_cnt = 0;
        for (int k = 7; k <= 150; k++) begin
            tick(1);
            if (bus.sync_out) sync_cnt++;
            if (k == 139) chk("slot_23_start", 32'(bus.slot), 23);
            if (k == 144) chk("slot_23_end",   32'(bus.slot), 23);
            if (k == 145) chk("slot_wrap",     32'(bus.slot), 0);
        end
        chk("sync_width", 32'(sync_cnt), 6);

        // stall while c2 is high at phase 3 of slot 1
        tick(4);
        chk("pre_stall_c2",   32'(bus.c2),   1);
        chk("pre_stall_slot", 32'(bus.slot), 1);
        bus.clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_c1",   32'(bus.c1),   0);
            chk("stall_c2",   32'(bus.c2),   1);
            chk("stall_slot", 32'(bus.slot), 1);
        end
        bus.clk_en = 1'b1;
        tick(1);
        chk("resume_ph4_c2", 32'(bus.c2), 1);
        chk("resume_ph4_c1", 32'(bus.c1), 0);
        tick(1);
        chk("resume_ph5_c2", 32'(bus.c2), 0);
        tick(1);
        chk("resume_next_c1",   32'(bus.c1),   1);
        chk("resume_next_slot", 32'(bus.slot), 2);

        // realign at slot 10 phase 2 while stalled
        tick(50);
        chk("pre_sync_slot", 32'(bus.slot), 10);
        bus.clk_en  = 1'b0;
        bus.sync_in = 1'b1;
        tick(1);
        chk("sync_c1",   32'(bus.c1),   0);
        chk("sync_c2",   32'(bus.c2),   0);
        chk("sync_slot", 32'(bus.slot), 0);
        bus.clk_en = 1'b1;
        tick(3);
        chk("sync_held_c1",   32'(bus.c1),   0);
        chk("sync_held_slot", 32'(bus.slot), 0);
        bus.sync_in = 1'b0;
        tick(1);
        chk("post_sync_c1", 32'(bus.c1), 1);

        // async reset in the middle of a c1 phase at slot 5
        tick(30);
        chk("pre_rst_c1",   32'(bus.c1),   1);
        chk("pre_rst_slot", 32'(bus.slot), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_c1",   32'(bus.c1),       0);
        chk("async_rst_c2",   32'(bus.c2),       0);
        chk("async_rst_slot", 32'(bus.slot),     0);
        chk("async_rst_sync", 32'(bus.sync_out), 0);
        @(posedge MCLK);
        #1;
        rst = 1'b1;
        tick(1);
        chk("post_rst_c1", 32'(bus.c1), 1);

`ifdef YM_CLK_PHASE_DBG_EN
        tick(65537 * DIV - 1);
        chk("dbg_wrap", 32'(bus.dbg_periods), 1);
`else
        chk("dbg_tied", 32'(bus.dbg_periods), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
